// File: rtl/anspwm_sched.sv
// anspwm_sched
//   Round-robin scheduler sharing one cascaded anspwm modulator chain among
//   NCH requesters. A granted requester's target is loaded into the cascade,
//   held for a programmable dwell, then completion is pulsed and the block
//   re-arbitrates.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   en         1 = new grants allowed; 0 = finish current grant, then idle
//   dwell_cfg  RUN length in cycles, sampled in LOAD (0 behaves as 1)
//   req_valid  per-requester target valid
//   req_tgt    packed targets, requester i at [i*TW +: TW]
//   req_ready  one-hot accept pulse, LOAD cycle only
//   tgt_out    target driven to the cascade tgt_in
//   mod_clr    active-high cascade clear, asserted in LOAD
//   busy       1 in every state except IDLE
//   grant_id   index of the current or last grant
//   done       1-cycle pulse in DONE
//
// Build option
//   ANSPWM_SLEW_LIMIT_EN : tgt_out slews toward the target by at most STEP
//   per RUN cycle instead of jumping in LOAD; mod_clr is never asserted and
//   RUN ends only once the dwell has expired and tgt_out has arrived.
//
// state | meaning
// IDLE  | waiting for en && any req_valid
// LOAD  | handshake with winner, load target, clear cascade, load dwell
// RUN   | hold (or slew to) target until the dwell counter expires
// DONE  | completion pulse, advance round-robin pointer

module anspwm_sched #(
    parameter int NCH  = 4,
    parameter int TW   = 32,
    parameter int DW   = 16,
    parameter int STEP = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DW-1:0]            dwell_cfg,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH*TW-1:0]        req_tgt,
    output logic [NCH-1:0]           req_ready,
    output logic [TW-1:0]            tgt_out,
    output logic                     mod_clr,
    output logic                     busy,
    output logic [$clog2(NCH)-1:0]   grant_id,
    output logic                     done
);

    localparam int GW = $clog2(NCH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (NCH < 2 || NCH > 16 || STEP < 1) begin : g_param_check
        $error("anspwm_sched: NCH must be 2..16 and STEP >= 1");
    end

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [TW-1:0] tgt_out_q, tgt_out_d;

    logic          arb_found;
    logic [GW-1:0] arb_id;
    logic [GW:0]   arb_sum;
    logic [TW-1:0] sel_tgt;

    // Scan requesters starting at the round-robin pointer; first valid wins.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        arb_sum   = '0;
        for (int i = 0; i < NCH; i++) begin
            arb_sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (arb_sum >= (GW+1)'(NCH)) begin
                arb_sum = arb_sum - (GW+1)'(NCH);
            end
            if (!arb_found && req_valid[arb_sum[GW-1:0]]) begin
                arb_found = 1'b1;
                arb_id    = arb_sum[GW-1:0];
            end
        end
    end

    assign sel_tgt = req_tgt[grant_id_q*TW +: TW];

`ifdef ANSPWM_SLEW_LIMIT_EN
    logic [TW-1:0] target_q, target_d;
    logic [TW:0]   slew_diff;
    logic [TW:0]   slew_neg;
    logic [TW-1:0] slew_mag;
    logic [TW-1:0] slew_step;
    logic [TW-1:0] slew_next;

    // One extra bit keeps the sign so a downward move never wraps.
    always_comb begin
        slew_diff = {1'b0, target_q} - {1'b0, tgt_out_q};
        slew_neg  = (TW+1)'(0) - slew_diff;
        slew_mag  = slew_diff[TW] ? slew_neg[TW-1:0] : slew_diff[TW-1:0];
        slew_step = (slew_mag > TW'(STEP)) ? TW'(STEP) : slew_mag;
        slew_next = slew_diff[TW] ? (tgt_out_q - slew_step) : (tgt_out_q + slew_step);
    end
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        dwell_d    = dwell_q;
        tgt_out_d  = tgt_out_q;
`ifdef ANSPWM_SLEW_LIMIT_EN
        target_d   = target_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en && arb_found) begin
                    state_d    = S_LOAD;
                    grant_id_d = arb_id;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                dwell_d = (dwell_cfg == '0) ? '0 : (dwell_cfg - DW'(1));
`ifdef ANSPWM_SLEW_LIMIT_EN
                target_d = sel_tgt;
`else
                tgt_out_d = sel_tgt;
`endif
            end
            S_RUN: begin
`ifdef ANSPWM_SLEW_LIMIT_EN
                if (dwell_q == '0 && tgt_out_q == target_q) begin
                    state_d = S_DONE;
                end else begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DW'(1);
                    end
                    tgt_out_d = slew_next;
                end
`else
                if (dwell_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    dwell_d = dwell_q - DW'(1);
                end
`endif
            end
            default: begin
                state_d  = S_IDLE;
                rr_ptr_d = (grant_id_q == GW'(NCH-1)) ? '0 : (grant_id_q + GW'(1));
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            dwell_q    <= '0;
            tgt_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            dwell_q    <= dwell_d;
            tgt_out_q  <= tgt_out_d;
        end
    end

`ifdef ANSPWM_SLEW_LIMIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q <= '0;
        end else begin
            target_q <= target_d;
        end
    end

    // The cascade is never cleared when slewing; it tracks tgt_out smoothly.
    assign mod_clr = 1'b0;
`else
    assign mod_clr = (state_q == S_LOAD);
`endif

    assign req_ready = (state_q == S_LOAD) ? (NCH'(1) << grant_id_q) : '0;
    assign tgt_out   = tgt_out_q;
    assign busy      = (state_q != S_IDLE);
    assign grant_id  = grant_id_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_anspwm_sched.sv
module tb_anspwm_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] dwell_cfg;
    logic [3:0]  req_valid;
    logic [127:0] req_tgt;
    logic [3:0]  req_ready;
    logic [31:0] tgt_out;
    logic        mod_clr;
    logic        busy;
    logic [1:0]  grant_id;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] tgt_tab [4];

    anspwm_sched #(.NCH(4), .TW(32), .DW(16), .STEP(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dwell_cfg (dwell_cfg),
        .req_valid (req_valid),
        .req_tgt   (req_tgt),
        .req_ready (req_ready),
        .tgt_out   (tgt_out),
        .mod_clr   (mod_clr),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at an IDLE sample point where the next edge must start a grant
    // to requester id. Follows LOAD, RUN and DONE and returns at the IDLE
    // sample after DONE.
    task automatic run_grant(input int id, input int d_eff, input bit drop_en);
        logic [15:0] saved_dwell;
        int n;
        tick();
        chk("load_ready", 32'(req_ready), 32'(1 << id));
        chk("load_clr", 32'(mod_clr), 32'd1);
        chk("load_gid", 32'(grant_id), 32'(id));
        chk("load_busy", 32'(busy), 32'd1);
        tick();
        chk("run_tgt", tgt_out, tgt_tab[id]);
        chk("run_clr", 32'(mod_clr), 32'd0);
        chk("run_ready", 32'(req_ready), 32'd0);
        if (drop_en) en = 1'b0;
        saved_dwell = dwell_cfg;
        dwell_cfg = ~dwell_cfg;
        n = 0;
        while (n < d_eff + 5) begin
            tick();
            n++;
            if (done) break;
        end
        chk("done_lat", 32'(n), 32'(d_eff));
        chk("done_gid", 32'(grant_id), 32'(id));
        dwell_cfg = saved_dwell;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold", tgt_out, tgt_tab[id]);
    endtask

    initial begin
        tgt_tab[0] = 32'hA000_0000;
        tgt_tab[1] = 32'h1111_1111;
        tgt_tab[2] = 32'h1234_5678;
        tgt_tab[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) req_tgt[i*32 +: 32] = tgt_tab[i];
        rst       = 1'b0;
        en        = 1'b1;
        dwell_cfg = 16'd5;
        req_valid = 4'b1111;

        // Reset with every requester valid: all outputs stay low.
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_tgt", tgt_out, 32'd0);
        chk("rst_clr", 32'(mod_clr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;

        // First grant after reset goes to requester 0, then round robin.
        run_grant(0, 5, 1'b0);
        run_grant(1, 5, 1'b0);
        run_grant(2, 5, 1'b0);
        run_grant(3, 5, 1'b0);
        run_grant(0, 5, 1'b0);
        req_valid = 4'b0000;
        tick();
        chk("idle_novalid", 32'(busy), 32'd0);

        // Single requester 2, dwell 5.
        req_valid = 4'b0100;
        run_grant(2, 5, 1'b0);
        req_valid = 4'b0000;

        // Pointer at 3: requester 1 wins; dwell 0 behaves as 1.
        dwell_cfg = 16'd0;
        req_valid = 4'b0010;
        run_grant(1, 1, 1'b0);
        req_valid = 4'b0000;

        // Pointer at 2: scan wraps past 3 to requester 0.
        dwell_cfg = 16'd3;
        req_valid = 4'b0011;
        run_grant(0, 3, 1'b0);
        req_valid = 4'b0000;

        // Maximum dwell.
        dwell_cfg = 16'hFFFF;
        req_valid = 4'b1000;
        run_grant(3, 65535, 1'b0);
        req_valid = 4'b0000;

        // en dropped during RUN: grant completes, then block stays idle.
        dwell_cfg = 16'd2;
        req_valid = 4'b0001;
        run_grant(0, 2, 1'b1);
        tick();
        tick();
        tick();
        tick();
        chk("en0_busy", 32'(busy), 32'd0);
        chk("en0_ready", 32'(req_ready), 32'd0);
        en = 1'b1;
        run_grant(0, 2, 1'b0);
        req_valid = 4'b0000;

        // Asynchronous reset mid-RUN abandons the grant.
        dwell_cfg = 16'd10;
        req_valid = 4'b0100;
        tick();
        chk("ar_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("ar_tgt_run", tgt_out, tgt_tab[2]);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_tgt", tgt_out, 32'd0);
        chk("ar_gid", 32'(grant_id), 32'd0);
        tick();
        tick();
        chk("ar_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();
        chk("ar_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
